// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake: single-cycle logic/arithmetic ops,
// plus iterative one-bit-per-cycle shifts and a radix-2 shift-add multiplier.
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [3:0]       ALUControl_in,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [WIDTH-1:0] Result_out,
   output logic             Zero_out,
   output logic             Error_out
);

   // One extra bit so the counter can hold WIDTH itself for the multiply.
   localparam int CNT_W = SHAMT_W + 1;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1011;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q,  state_d;
   logic [3:0]       op_q,     op_d;
   logic [WIDTH-1:0] work_q,   work_d;
   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             zero_q,   zero_d;
   logic             error_q,  error_d;

   logic             accept;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] step_res;

   assign ready_out  = (state_q == IDLE);
   assign valid_out  = (state_q == DONE);
   assign accept     = valid_in && ready_out;
   assign Result_out = result_q;
   assign Zero_out   = zero_q;
   assign Error_out  = error_q;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      alu_res = '0;
      case (ALUControl_in)
         OP_AND:  alu_res = A_in & B_in;
         OP_OR:   alu_res = A_in | B_in;
         OP_ADD:  alu_res = A_in + B_in;
         OP_SUB:  alu_res = A_in - B_in;
         OP_SLT:  alu_res[0] = ($signed(A_in) < $signed(B_in));
         OP_NOR:  alu_res = ~(A_in | B_in);
         default: alu_res = '0;
      endcase
   end

   // One iteration of the in-flight op; work_q is the shift value or the product accumulator.
   always_comb begin
      step_res = work_q;
      case (op_q)
         OP_SLL:  step_res = work_q << 1;
         OP_SRL:  step_res = work_q >> 1;
         OP_SRA:  step_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         OP_MUL:  step_res = work_q + (mplier_q[0] ? mcand_q : '0);
         default: step_res = work_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      work_d   = work_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      zero_d   = zero_q;
      error_d  = error_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = ALUControl_in;
               error_d = 1'b0;
               case (ALUControl_in)
                  OP_SLL, OP_SRL, OP_SRA: begin
                     if (B_in[SHAMT_W-1:0] == '0) begin
                        result_d = A_in;
                        zero_d   = (A_in == '0);
                        state_d  = DONE;
                     end else begin
                        work_d  = A_in;
                        cnt_d   = CNT_W'(B_in[SHAMT_W-1:0]);
                        state_d = BUSY;
                     end
                  end
                  OP_MUL: begin
                     work_d   = '0;
                     mcand_d  = A_in;
                     mplier_d = B_in;
                     cnt_d    = CNT_W'(WIDTH);
                     state_d  = BUSY;
                  end
                  OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: begin
                     result_d = alu_res;
                     zero_d   = (alu_res == '0);
                     state_d  = DONE;
                  end
                  default: begin
                     result_d = '0;
                     zero_d   = 1'b1;
                     error_d  = 1'b1;
                     state_d  = DONE;
                  end
               endcase
            end
         end

         BUSY: begin
            work_d   = step_res;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               result_d = step_res;
               zero_d   = (step_res == '0);
               state_d  = DONE;
            end
         end

         DONE: begin
            if (ready_in) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         work_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         zero_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         work_q   <= work_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         zero_q   <= zero_d;
         error_q  <= error_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: behavioural reference model feeds a scoreboard queue,
// results are popped and compared when valid_out rises.
module tb_alu_exec_unit;

   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              valid_in;
   logic              ready_out;
   logic [3:0]        ALUControl_in;
   logic [WIDTH-1:0]  A_in;
   logic [WIDTH-1:0]  B_in;
   logic              valid_out;
   logic              ready_in;
   logic [WIDTH-1:0]  Result_out;
   logic              Zero_out;
   logic              Error_out;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             zero;
      logic             err;
      int               lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_in     (valid_in),
      .ready_out    (ready_out),
      .ALUControl_in(ALUControl_in),
      .A_in         (A_in),
      .B_in         (B_in),
      .valid_out    (valid_out),
      .ready_in     (ready_in),
      .Result_out   (Result_out),
      .Zero_out     (Zero_out),
      .Error_out    (Error_out)
   );

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t e;
      int   sh;
      sh    = int'(b[4:0]);
      e.res = '0;
      e.err = 1'b0;
      e.lat = 1;
      case (op)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0010: e.res = a + b;
         4'b0110: e.res = a - b;
         4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1100: e.res = ~(a | b);
         4'b1000: begin e.res = a << sh; e.lat = sh + 1; end
         4'b1001: begin e.res = a >> sh; e.lat = sh + 1; end
         4'b1010: begin e.res = $unsigned($signed(a) >>> sh); e.lat = sh + 1; end
         4'b1011: begin e.res = a * b; e.lat = WIDTH + 1; end
         default: e.err = 1'b1;
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   // Drives one request at a negedge; returns at the first negedge after the accept edge.
   task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int n = 0;
      while (!ready_out && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_issue", WIDTH'(ready_out), 1);
      ALUControl_in = op;
      A_in          = a;
      B_in          = b;
      valid_in      = 1'b1;
      sb.push_back(model(op, a, b));
      @(negedge clk);
      valid_in = 1'b0;
      A_in     = $urandom;
      B_in     = $urandom;
   endtask

   task automatic collect(input string tag, input bit release_after);
      exp_t e;
      int   lat = 1;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
         return;
      end
      if (sb[0].lat > 1) check({tag, "_busy_ready"}, WIDTH'(ready_out), 0);
      while (!valid_out && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_valid"}, WIDTH'(valid_out), 1);
      e = sb.pop_front();
      check({tag, "_result"},  Result_out,       e.res);
      check({tag, "_zero"},    WIDTH'(Zero_out), WIDTH'(e.zero));
      check({tag, "_error"},   WIDTH'(Error_out), WIDTH'(e.err));
      check({tag, "_latency"}, WIDTH'(lat),      WIDTH'(e.lat));
      if (release_after) begin
         @(negedge clk);
         check({tag, "_valid_drop"}, WIDTH'(valid_out), 0);
         check({tag, "_ready_back"}, WIDTH'(ready_out), 1);
         check({tag, "_result_hold"}, Result_out, e.res);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ops [11];
      int         seen;

      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
              4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0101};

      // Reset with a request pending: nothing may be accepted.
      reset         = 1'b1;
      valid_in      = 1'b1;
      ready_in      = 1'b1;
      ALUControl_in = 4'b0010;
      A_in          = 32'd1;
      B_in          = 32'd1;
      repeat (3) @(negedge clk);
      reset    = 1'b0;
      valid_in = 1'b0;
      check("rst_ready",  WIDTH'(ready_out), 1);
      check("rst_valid",  WIDTH'(valid_out), 0);
      check("rst_result", Result_out, 0);
      check("rst_zero",   WIDTH'(Zero_out), 0);
      check("rst_error",  WIDTH'(Error_out), 0);
      @(negedge clk);
      check("rst_no_accept", WIDTH'(valid_out), 0);

      issue(4'b0010, 32'h7FFF_FFFF, 32'd1);   collect("add_wrap", 1'b1);
      issue(4'b0110, 32'd5, 32'd5);           collect("sub_zero", 1'b1);
      issue(4'b1010, 32'h8000_0000, 32'd4);   collect("sra4", 1'b1);
      issue(4'b1010, 32'h8000_0000, 32'd0);   collect("sra0", 1'b1);
      issue(4'b1011, 32'h0001_0003, 32'd5);   collect("mul_small", 1'b1);
      issue(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF); collect("mul_ones", 1'b1);
      issue(4'b1000, 32'h0000_0001, 32'd31);  collect("sll31", 1'b1);
      issue(4'b1001, 32'h8000_0000, 32'd31);  collect("srl31", 1'b1);

      // Backpressure: result held, new requests ignored.
      ready_in = 1'b0;
      issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
      collect("slt_bp", 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            ALUControl_in = 4'b0010;
            A_in          = 32'd9;
            B_in          = 32'd9;
            valid_in      = 1'b1;
         end else begin
            valid_in = 1'b0;
         end
         @(negedge clk);
         if (i == 0 || i == 9) begin
            check("bp_result", Result_out, 32'd1);
            check("bp_valid",  WIDTH'(valid_out), 1);
            check("bp_ready",  WIDTH'(ready_out), 0);
         end
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      @(negedge clk);
      check("bp_release_valid", WIDTH'(valid_out), 0);
      check("bp_release_ready", WIDTH'(ready_out), 1);
      @(negedge clk);
      check("bp_ignored_req", WIDTH'(valid_out), 0);

      issue(4'b0011, 32'd3, 32'd4);           collect("illegal", 1'b1);
      issue(4'b0000, 32'hF0, 32'h3C);         collect("and_after_err", 1'b1);

      // Reset during the tenth cycle of a multiply.
      issue(4'b1011, 32'h1234_5678, 32'h0000_0FFF);
      void'(sb.pop_back());
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_valid",  WIDTH'(valid_out), 0);
      check("abort_ready",  WIDTH'(ready_out), 1);
      check("abort_result", Result_out, 0);
      check("abort_error",  WIDTH'(Error_out), 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (valid_out) seen++;
      end
      check("abort_no_result", WIDTH'(seen), 0);
      issue(4'b0010, 32'd2, 32'd2);           collect("add_after_abort", 1'b1);

      // Randomised mix across every code, including an illegal one.
      for (int i = 0; i < 14; i++) begin
         logic [3:0] op;
         op = ops[$urandom_range(0, 10)];
         issue(op, $urandom, $urandom);
         collect("rand", 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
